// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
//   Iterative multi-cycle multiplier for the 16-bit datapath. Operands come from
//   the register-file read ports, the result leaves as a one-cycle write-back
//   triple (wr_en, wr_addr, wr_data). Each operation retires one operand bit per
//   clock for WIDTH clocks, followed by a single write-back cycle. A new start can
//   be accepted on the edge that leaves write-back, so operations can run
//   back to back.
//
//   Optional feature macro: SEQ_MUL_DIV_EN
//     defined   : op_i = 1 selects unsigned restoring division. The result is the
//                 quotient. A zero divisor gives all-ones and div_by_zero_o.
//     undefined : op_i is ignored, div_by_zero_o is tied low, no divider logic.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   start_i        request a new operation (sampled in IDLE and WB only)
//   op_i           0 = multiply, 1 = divide (divider builds only)
//   dest_addr_i    destination register of the result
//   op_a_i         multiplicand / dividend
//   op_b_i         multiplier / divisor
//   busy_o         operation in progress (RUN and WB)
//   done_o         one-cycle completion pulse, same cycle as wr_en_o
//   wr_en_o        register-file write strobe
//   wr_addr_o      latched destination address
//   wr_data_o      result, held until the next write-back or reset
//   div_by_zero_o  one-cycle flag with done_o: divide with a zero divisor
//
// States
//   S_IDLE | waiting for start_i
//   S_RUN  | one operand bit per cycle, WIDTH cycles
//   S_WB   | write-back cycle, wr_en_o = done_o = 1
// -----------------------------------------------------------------------------
module seq_mul_unit #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  op_i,
    input  logic [REG_ADDR_W-1:0] dest_addr_i,
    input  logic [WIDTH-1:0]      op_a_i,
    input  logic [WIDTH-1:0]      op_b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [WIDTH-1:0]      wr_data_o,
    output logic                  div_by_zero_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      count_q;
    logic [WIDTH-1:0]      a_q;      // multiplicand (shifts left) / dividend-quotient
    logic [WIDTH-1:0]      b_q;      // multiplier (shifts right) / divisor
    logic [WIDTH-1:0]      acc_q;    // product accumulator / partial remainder
    logic [REG_ADDR_W-1:0] dest_q;

    logic [WIDTH-1:0]      a_d;
    logic [WIDTH-1:0]      b_d;
    logic [WIDTH-1:0]      acc_d;
    logic [WIDTH-1:0]      result_d;
    logic                  div0_d;
    logic                  accept;

`ifdef SEQ_MUL_DIV_EN
    logic                  op_q;
    logic [WIDTH:0]        rem_shift;
    logic [WIDTH:0]        rem_diff;
`else
    logic                  unused_op;
    assign unused_op = op_i;
`endif

    // Start is honoured in IDLE and on the edge that leaves WB.
    assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_WB));

    // One iteration of the datapath, applied on every RUN edge.
    always_comb begin
        a_d      = a_q << 1;
        b_d      = b_q >> 1;
        acc_d    = b_q[0] ? (acc_q + a_q) : acc_q;
        result_d = acc_d;
        div0_d   = 1'b0;
`ifdef SEQ_MUL_DIV_EN
        // Restoring division: dividend bits shift out of a_q into the partial
        // remainder while quotient bits shift into a_q from the right.
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (op_q) begin
            b_d = b_q;
            if (!rem_diff[WIDTH]) begin
                acc_d = rem_diff[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
            // A zero divisor would let the remainder overflow, so the
            // all-ones quotient is forced rather than computed.
            div0_d   = (b_q == '0);
            result_d = div0_d ? '1 : a_d;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            dest_q        <= '0;
`ifdef SEQ_MUL_DIV_EN
            op_q          <= 1'b0;
`endif
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o        <= 1'b0;
            wr_en_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            if (accept) begin
                a_q     <= op_a_i;
                b_q     <= op_b_i;
                dest_q  <= dest_addr_i;
`ifdef SEQ_MUL_DIV_EN
                op_q    <= op_i;
`endif
                acc_q   <= '0;
                count_q <= '0;
                busy_o  <= 1'b1;
                state_q <= S_RUN;
            end else begin
                case (state_q)
                    S_RUN: begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        acc_q   <= acc_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_CNT) begin
                            state_q       <= S_WB;
                            wr_en_o       <= 1'b1;
                            done_o        <= 1'b1;
                            wr_addr_o     <= dest_q;
                            wr_data_o     <= result_d;
                            div_by_zero_o <= div0_d;
                        end
                    end
                    S_WB: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
module tb_seq_mul_unit;

    localparam int WIDTH      = 16;
    localparam int REG_ADDR_W = 2;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  op;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic                  busy;
    logic                  done;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  div_by_zero;

    int passed = 0;
    int total  = 0;

    seq_mul_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .op_i          (op),
        .dest_addr_i   (dest_addr),
        .op_a_i        (op_a),
        .op_b_i        (op_b),
        .busy_o        (busy),
        .done_o        (done),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .div_by_zero_o (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation at a negedge, let the next rising edge accept it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [REG_ADDR_W-1:0] d, input logic o);
        op_a      = a;
        op_b      = b;
        dest_addr = d;
        op        = o;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count negedges with busy=1 and wr_en=0 until wr_en is seen (bounded).
    task automatic wait_wb(output int n_busy, output int n_cycles);
        n_busy   = 0;
        n_cycles = 0;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) break;
            n_cycles++;
            if (busy === 1'b1) n_busy++;
            if (n_cycles >= 40) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        dest_addr = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({busy, done, wr_en, div_by_zero} !== 4'b0000)
            $display("FAIL reset_flags: got busy/done/wr_en/dbz=%b expected 0000",
                     {busy, done, wr_en, div_by_zero});
        else passed++;
        total++;
        if (wr_data !== 16'h0000 || wr_addr !== 2'd0)
            $display("FAIL reset_data: got wr_data=%h wr_addr=%0d expected 0000/0", wr_data, wr_addr);
        else passed++;
    endtask

    task automatic test_mul_basic();
        int nb, nc;
        issue(16'd3, 16'd5, 2'd2, 1'b0);
        wait_wb(nb, nc);
        total++;
        if (nc !== 16 || nb !== 16)
            $display("FAIL mul_latency: got %0d cycles (%0d busy) before wr_en, expected 16", nc, nb);
        else passed++;
        total++;
        if ({wr_en, done, busy, div_by_zero} !== 4'b1110 || wr_addr !== 2'd2 || wr_data !== 16'h000F)
            $display("FAIL mul_3x5: got en/done/busy/dbz=%b addr=%0d data=%h expected 1110 2 000f",
                     {wr_en, done, busy, div_by_zero}, wr_addr, wr_data);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || wr_data !== 16'h000F)
            $display("FAIL mul_after_wb: got busy=%b wr_en=%b done=%b data=%h expected 0 0 0 000f",
                     busy, wr_en, done, wr_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int nb, nc;
        @(negedge clk);
        issue(16'h1234, 16'h0100, 2'd1, 1'b0);
        wait_wb(nb, nc);
        total++;
        if (nc !== 16 || wr_data !== 16'h3400 || wr_addr !== 2'd1)
            $display("FAIL mul_trunc: got %0d cycles data=%h addr=%0d expected 16 3400 1", nc, wr_data, wr_addr);
        else passed++;
        // Start presented during WB: accepted on the edge leaving WB.
        issue(16'hFFFF, 16'hFFFF, 2'd3, 1'b0);
        total++;
        if (busy !== 1'b1 || wr_en !== 1'b0)
            $display("FAIL b2b_no_gap: got busy=%b wr_en=%b expected 1 0", busy, wr_en);
        else passed++;
        wait_wb(nb, nc);
        total++;
        if (nc !== 16 || nb !== 16)
            $display("FAIL b2b_latency: got %0d cycles (%0d busy) expected 16", nc, nb);
        else passed++;
        total++;
        if (wr_data !== 16'h0001 || wr_addr !== 2'd3)
            $display("FAIL b2b_ffff: got data=%h addr=%0d expected 0001 3", wr_data, wr_addr);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int nb, nc, writes;
        @(negedge clk);
        issue(16'd7, 16'd9, 2'd1, 1'b0);
        repeat (3) @(negedge clk);
        issue(16'd2, 16'd2, 2'd3, 1'b0);
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        dest_addr = 2'd0;
        wait_wb(nb, nc);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 16'h003F)
            $display("FAIL ignore_start: got wr_en=%b addr=%0d data=%h expected 1 1 003f", wr_en, wr_addr, wr_data);
        else passed++;
        writes = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en === 1'b1) writes++;
        end
        total++;
        if (writes !== 0 || busy !== 1'b0)
            $display("FAIL ignore_single_write: got %0d extra writes busy=%b expected 0 0", writes, busy);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int writes;
        @(negedge clk);
        issue(16'd3, 16'd5, 2'd2, 1'b0);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || wr_data !== 16'h0000)
            $display("FAIL abort_async: got busy=%b data=%h expected 0 0000", busy, wr_data);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        writes = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en === 1'b1 || done === 1'b1) writes++;
        end
        total++;
        if (writes !== 0 || busy !== 1'b0)
            $display("FAIL abort_no_write: got %0d strobes busy=%b expected 0 0", writes, busy);
        else passed++;
    endtask

`ifdef SEQ_MUL_DIV_EN
    task automatic test_div();
        int nb, nc;
        @(negedge clk);
        issue(16'd100, 16'd7, 2'd2, 1'b1);
        wait_wb(nb, nc);
        total++;
        if (nc !== 16 || wr_data !== 16'h000E || div_by_zero !== 1'b0 || done !== 1'b1)
            $display("FAIL div_100_7: got %0d cycles data=%h dbz=%b done=%b expected 16 000e 0 1",
                     nc, wr_data, div_by_zero, done);
        else passed++;
        @(negedge clk);
        issue(16'd5, 16'd0, 2'd1, 1'b1);
        wait_wb(nb, nc);
        total++;
        if (nc !== 16 || wr_data !== 16'hFFFF || div_by_zero !== 1'b1 || done !== 1'b1 || wr_addr !== 2'd1)
            $display("FAIL div_by_zero: got %0d cycles data=%h dbz=%b done=%b addr=%0d expected 16 ffff 1 1 1",
                     nc, wr_data, div_by_zero, done, wr_addr);
        else passed++;
        @(negedge clk);
        total++;
        if (div_by_zero !== 1'b0 || wr_data !== 16'hFFFF)
            $display("FAIL dbz_pulse: got dbz=%b data=%h expected 0 ffff", div_by_zero, wr_data);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
`ifdef SEQ_MUL_DIV_EN
        test_div();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
